// File: rtl/conv_mac.sv
// Sequential SLICE x SLICE convolution MAC: one product per cycle into a signed accumulator.
// Optional build macro CONV_MAC_RELU_EN clamps negative sums to zero on the result port.
module conv_mac #(
    parameter int DW    = 8,
    parameter int SLICE = 3,
    parameter int ACCW  = 2*DW+4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [SLICE*SLICE*DW-1:0]   win_data,
    input  logic                        wload,
    input  logic [SLICE*SLICE*DW-1:0]   kdata,
    output logic                        busy,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [ACCW-1:0]             result
);

    localparam int N    = SLICE*SLICE;
    localparam int IDXW = (N > 1) ? $clog2(N) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MAC  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]               state_q, state_d;
    logic [IDXW-1:0]          idx_q, idx_d;
    logic signed [ACCW-1:0]   acc_q, acc_d;
    logic [N*DW-1:0]          win_q, win_d;
    logic [N*DW-1:0]          wgt_q, wgt_d;

    logic signed [DW-1:0]     w_e, x_e;
    logic signed [2*DW-1:0]   w_ext, x_ext, prod;
    logic signed [ACCW-1:0]   prod_ext;

    function automatic logic signed [ACCW-1:0] sext_prod(input logic signed [2*DW-1:0] p);
        return {{(ACCW-2*DW){p[2*DW-1]}}, p};
    endfunction

    function automatic logic [ACCW-1:0] post_act(input logic signed [ACCW-1:0] s);
`ifdef CONV_MAC_RELU_EN
        return s[ACCW-1] ? '0 : s;
`else
        return s;
`endif
    endfunction

    // Element select and signed DW x DW product; low 2*DW bits of the widened product are exact.
    always_comb begin
        w_e      = wgt_q[DW*int'(idx_q) +: DW];
        x_e      = win_q[DW*int'(idx_q) +: DW];
        w_ext    = {{DW{w_e[DW-1]}}, w_e};
        x_ext    = {{DW{x_e[DW-1]}}, x_e};
        prod     = w_ext * x_ext;
        prod_ext = sext_prod(prod);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        win_d   = win_q;
        wgt_d   = wgt_q;
        case (state_q)
            S_IDLE: begin
                // Kernel load wins over a simultaneous window offer.
                if (wload) begin
                    wgt_d = kdata;
                end else if (in_valid) begin
                    win_d   = win_data;
                    acc_d   = '0;
                    idx_d   = '0;
                    state_d = S_MAC;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (idx_q == IDXW'(N-1)) begin
                    idx_d   = '0;
                    state_d = S_OUT;
                end else begin
                    idx_d = idx_q + IDXW'(1);
                end
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            acc_q   <= '0;
            win_q   <= '0;
            wgt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            acc_q   <= acc_d;
            win_q   <= win_d;
            wgt_q   <= wgt_d;
        end
    end

    assign in_ready  = rst && (state_q == S_IDLE) && !wload;
    assign busy      = (state_q == S_MAC) || (state_q == S_OUT);
    assign out_valid = (state_q == S_OUT);
    assign result    = post_act(acc_q);

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac (DW=8, SLICE=3, ACCW=20); honours CONV_MAC_RELU_EN if defined.
module tb_conv_mac;

    localparam int DW    = 8;
    localparam int SLICE = 3;
    localparam int N     = SLICE*SLICE;
    localparam int ACCW  = 20;

    logic                  clk;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [N*DW-1:0]       win_data;
    logic                  wload;
    logic [N*DW-1:0]       kdata;
    logic                  busy;
    logic                  out_valid;
    logic                  out_ready;
    logic [ACCW-1:0]       result;

    int total = 0;
    int bad   = 0;

    conv_mac #(.DW(DW), .SLICE(SLICE), .ACCW(ACCW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .win_data  (win_data),
        .wload     (wload),
        .kdata     (kdata),
        .busy      (busy),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [N*DW-1:0] rep(input logic [DW-1:0] v);
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
        return r;
    endfunction

    function automatic logic [N*DW-1:0] ramp();
        logic [N*DW-1:0] r;
        for (int i = 0; i < N; i++) r[i*DW +: DW] = DW'(i+1);
        return r;
    endfunction

    task automatic load_kernel(input logic [N*DW-1:0] k);
        @(negedge clk);
        wload = 1'b1;
        kdata = k;
        @(negedge clk);
        wload = 1'b0;
        kdata = '0;
    endtask

    // Offers one window, returns the number of edges from acceptance to out_valid (-1 on timeout).
    task automatic send_window(input logic [N*DW-1:0] w, output int lat);
        @(negedge clk);
        in_valid = 1'b1;
        win_data = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        win_data = '0;
        lat = -1;
        for (int i = 1; i <= 50; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic pop();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst      = 1'b0;
        in_valid = 1'b1;
        win_data = rep(8'd5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid cyc=%0d got=%b exp=0", c, out_valid); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy cyc=%0d got=%b exp=0", c, busy); end
            total++; if (result !== '0) begin bad++; $display("FAIL reset_result cyc=%0d got=%0h exp=0", c, result); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        win_data = '0;
        #1;
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_wload_priority();
        @(negedge clk);
        wload    = 1'b1;
        kdata    = rep(8'd1);
        in_valid = 1'b1;
        win_data = rep(8'd7);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL wload_in_ready got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        wload    = 1'b0;
        in_valid = 1'b0;
        kdata    = '0;
        win_data = '0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL wload_not_accepted busy=%b exp=0", busy); end
    endtask

    task automatic test_basic();
        int lat;
        send_window(ramp(), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL basic_latency got=%0d exp=9", lat); end
        total++; if (result !== ACCW'(45)) begin bad++; $display("FAIL basic_result got=%0d exp=45", $signed(result)); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL basic_busy_out got=%b exp=1", busy); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL basic_in_ready_out got=%b exp=0", in_ready); end
        pop();
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_out_valid_drop got=%b exp=0", out_valid); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy_idle got=%b exp=0", busy); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_in_ready_idle got=%b exp=1", in_ready); end
    endtask

    task automatic test_negative();
        int lat;
        logic [ACCW-1:0] exp_r;
`ifdef CONV_MAC_RELU_EN
        exp_r = '0;
`else
        exp_r = ACCW'(-18);
`endif
        load_kernel(rep(8'hFF));
        send_window(rep(8'd2), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL neg_latency got=%0d exp=9", lat); end
        total++; if (result !== exp_r) begin bad++; $display("FAIL neg_result got=%0d exp=%0d", $signed(result), $signed(exp_r)); end
        pop();
    endtask

    task automatic test_extreme();
        int lat;
        logic [ACCW-1:0] exp_r;
        load_kernel(rep(8'h80));
        send_window(rep(8'h80), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL extreme_latency got=%0d exp=9", lat); end
        total++; if (result !== ACCW'(147456)) begin bad++; $display("FAIL extreme_result got=%0d exp=147456", $signed(result)); end
        pop();
        // Weights persist: -128 * 1 * 9 = -1152.
`ifdef CONV_MAC_RELU_EN
        exp_r = '0;
`else
        exp_r = ACCW'(-1152);
`endif
        send_window(rep(8'd1), lat);
        total++; if (result !== exp_r) begin bad++; $display("FAIL persist_result got=%0d exp=%0d", $signed(result), $signed(exp_r)); end
        pop();
    endtask

    task automatic test_backpressure();
        int lat;
        load_kernel(rep(8'd1));
        send_window(rep(8'd3), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL bp_latency got=%0d exp=9", lat); end
        in_valid = 1'b1;
        win_data = rep(8'd100);
        wload    = 1'b1;
        kdata    = '0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            #1;
            total++; if (result !== ACCW'(27)) begin bad++; $display("FAIL bp_result cyc=%0d got=%0d exp=27", c, $signed(result)); end
            total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL bp_out_valid cyc=%0d got=%b exp=1", c, out_valid); end
            total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
        end
        in_valid = 1'b0;
        win_data = '0;
        wload    = 1'b0;
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_no_bypass got=%b exp=0", in_ready); end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drop got=%b exp=0", out_valid); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_next got=%b exp=1", in_ready); end
        send_window(rep(8'd1), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL bp_next_latency got=%0d exp=9", lat); end
        total++; if (result !== ACCW'(9)) begin bad++; $display("FAIL bp_next_result got=%0d exp=9", $signed(result)); end
        pop();
    endtask

    task automatic test_reset_mid_mac();
        int lat;
        int seen;
        load_kernel(rep(8'd1));
        @(negedge clk);
        in_valid = 1'b1;
        win_data = ramp();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        win_data = '0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", busy); end
        total++; if (result !== '0) begin bad++; $display("FAIL midrst_result got=%0d exp=0", $signed(result)); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        @(negedge clk);
        rst  = 1'b1;
        seen = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        total++; if (seen !== 0) begin bad++; $display("FAIL midrst_no_result got=%0d exp=0", seen); end
        send_window(ramp(), lat);
        total++; if (lat !== 9) begin bad++; $display("FAIL midrst_latency got=%0d exp=9", lat); end
        total++; if (result !== '0) begin bad++; $display("FAIL midrst_cleared_kernel got=%0d exp=0", $signed(result)); end
        pop();
    endtask

    initial begin
        rst       = 1'b0;
        in_valid  = 1'b0;
        win_data  = '0;
        wload     = 1'b0;
        kdata     = '0;
        out_ready = 1'b0;
        test_reset();
        test_wload_priority();
        test_basic();
        test_negative();
        test_extreme();
        test_backpressure();
        test_reset_mid_mac();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
